// File: rtl/lram_fb_reader.sv
// lram_fb_reader: burst reader from LRAM into a first-word fall-through FIFO, with credit-based read issue.
module lram_fb_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [15:0]       length_i,
  input  logic              lramready_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_clk_en_o,
  input  logic [31:0]       rd_data_i,
  input  logic              rd_datavalid_i,
  output logic [31:0]       pix_data_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, WAIT_RDY, READ, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] issue_q, issue_d, left_q, left_d;
  logic [CW-1:0] out_q, out_d, cnt_q, cnt_d;
  logic [PW-1:0] wp_q, rp_q;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic done_q, done_d, ovf_q, ovf_d;
  logic issue, push, pop, credit;
  assign rd_addr_o   = addr_q;
  assign rd_clk_en_o = issue;
  assign pix_valid_o = cnt_q != '0;
  assign pix_data_o  = pix_valid_o ? mem_q[rp_q] : '0;
  assign busy_o      = state_q != IDLE;
  assign done_o      = done_q;
  assign overflow_o  = ovf_q;
  always_comb begin
    // credit counts words in flight plus words held, so the FIFO can never overflow
    credit  = ({1'b0, out_q} + {1'b0, cnt_q}) < (CW + 1)'(FIFO_DEPTH);
    issue   = state_q == READ && lramready_i && credit;
    push    = rd_datavalid_i && out_q != '0;
    pop     = pix_valid_o && pix_ready_i;
    state_d = state_q;
    addr_d  = addr_q;
    issue_d = issue_q;
    left_d  = pop ? left_q - 16'd1 : left_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | (rd_datavalid_i && out_q == '0);
    out_d   = out_q + CW'(issue) - CW'(push);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    case (state_q)
      IDLE: if (start_i) begin
        done_d  = length_i == 16'd0;
        state_d = length_i == 16'd0 ? IDLE : WAIT_RDY;
        addr_d  = length_i == 16'd0 ? addr_q : base_addr_i;
        issue_d = length_i;
        left_d  = length_i;
      end
      WAIT_RDY: state_d = lramready_i ? READ : WAIT_RDY;
      READ: if (issue) begin
        addr_d  = addr_q + ADDR_W'(1);
        issue_d = issue_q - 16'd1;
        state_d = issue_q == 16'd1 ? DRAIN : READ;
      end
      DRAIN: if (pop && left_q == 16'd1) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      issue_q <= '0;
      left_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      left_q  <= left_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_q + PW'(push);
      rp_q    <= rp_q + PW'(pop);
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk_i) if (push) mem_q[wp_q] <= rd_data_i;
endmodule

// File: tb/tb_lram_fb_reader.sv
// tb_lram_fb_reader: scoreboard bench with a 2-cycle-latency LRAM model and per-scenario tasks.
module tb_lram_fb_reader;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, lramready = 1'b0, pix_ready = 1'b0, spur = 1'b0;
  logic [15:0] base = '0, len = '0, rd_addr;
  logic [31:0] rd_data, pix_data;
  logic rd_en, rd_dv, pix_valid, busy, done, ovf;
  int total = 0, bad = 0, n_iss = 0, n_pop = 0, n_done = 0, cyc = 0;
  int iss_cyc[$];
  logic [15:0] ea[$];
  logic [31:0] ed[$];
  logic [1:0] pv = '0;
  logic [15:0] pa0 = '0, pa1 = '0;
  always #5 clk = ~clk;
  lram_fb_reader #(.FIFO_DEPTH(DEPTH), .ADDR_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_addr_i(base), .length_i(len),
    .lramready_i(lramready), .rd_addr_o(rd_addr), .rd_clk_en_o(rd_en), .rd_data_i(rd_data),
    .rd_datavalid_i(rd_dv), .pix_data_o(pix_data), .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
    .busy_o(busy), .done_o(done), .overflow_o(ovf));
  function automatic logic [31:0] f(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction
  always @(posedge clk) begin
    pv  <= {pv[0], rd_en};
    pa0 <= rd_addr;
    pa1 <= pa0;
  end
  assign rd_dv   = pv[1] | spur;
  assign rd_data = pv[1] ? f(pa1) : 32'hDEAD_BEEF;
  always @(negedge clk) begin
    cyc++;
    if (done) n_done++;
    if (rd_en) begin
      n_iss++;
      iss_cyc.push_back(cyc);
      total++;
      if (ea.size() == 0) begin
        bad++;
        $display("FAIL issue_addr unexpected read got=%h required=none", rd_addr);
      end else begin
        logic [15:0] e;
        e = ea.pop_front();
        if (rd_addr !== e) begin bad++; $display("FAIL issue_addr got=%h required=%h", rd_addr, e); end
      end
    end
    if (pix_valid && pix_ready) begin
      n_pop++;
      total++;
      if (ed.size() == 0) begin
        bad++;
        $display("FAIL pix_data unexpected word got=%h required=none", pix_data);
      end else begin
        logic [31:0] e;
        e = ed.pop_front();
        if (pix_data !== e) begin bad++; $display("FAIL pix_data got=%h required=%h", pix_data, e); end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    n_iss = 0; n_pop = 0; n_done = 0;
    iss_cyc.delete(); ea.delete(); ed.delete();
  endtask
  task automatic start_burst(input logic [15:0] b, input logic [15:0] l);
    for (int i = 0; i < int'(l); i++) begin
      logic [15:0] a;
      a = b + 16'(i);
      ea.push_back(a);
      ed.push_back(f(a));
    end
    base = b; len = l; start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick;
      ok = n_done > 0;
    end
  endtask
  task automatic test_reset;
    repeat (3) tick;
    total++;
    if ({rd_en, rd_addr, pix_valid, pix_data, busy, done, ovf} !== '0) begin
      bad++; $display("FAIL reset_in outputs got=%h required=0", {rd_en, rd_addr, pix_valid, pix_data, busy, done, ovf});
    end
    rst_n = 1'b1;
    tick;
    total++;
    if ({rd_en, rd_addr, pix_valid, pix_data, busy, done, ovf} !== '0) begin
      bad++; $display("FAIL reset_after outputs got=%h required=0", {rd_en, rd_addr, pix_valid, pix_data, busy, done, ovf});
    end
  endtask
  task automatic test_basic;
    bit ok;
    clr; pix_ready = 1'b1; lramready = 1'b1;
    start_burst(16'h4753, 16'd4);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_done timeout got=0 required=1"); end
    repeat (3) tick;
    total++; if (n_iss != 4 || n_pop != 4) begin bad++; $display("FAIL basic_counts iss=%0d pop=%0d required=4/4", n_iss, n_pop); end
    total++; if (n_done != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d required=1", n_done); end
    total++;
    if (iss_cyc.size() != 4 || iss_cyc[3] - iss_cyc[0] != 3) begin
      bad++; $display("FAIL basic_consecutive issues=%0d required=4 on consecutive cycles", iss_cyc.size());
    end
    total++; if (ovf !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_end ovf=%b busy=%b required=0/0", ovf, busy); end
  endtask
  task automatic test_backpressure;
    bit ok;
    logic [31:0] d0;
    clr; pix_ready = 1'b0;
    start_burst(16'h1000, 16'd10);
    repeat (20) tick;
    total++; if (n_iss != DEPTH) begin bad++; $display("FAIL bp_stall_issues got=%0d required=%0d", n_iss, DEPTH); end
    total++; if (pix_valid !== 1'b1 || pix_data !== f(16'h1000)) begin bad++; $display("FAIL bp_head got=%b/%h required=1/%h", pix_valid, pix_data, f(16'h1000)); end
    d0 = pix_data;
    repeat (3) tick;
    total++; if (pix_data !== d0) begin bad++; $display("FAIL bp_stable got=%h required=%h", pix_data, d0); end
    pix_ready = 1'b1;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_done timeout got=0 required=1"); end
    repeat (2) tick;
    total++; if (n_pop != 10 || ed.size() != 0) begin bad++; $display("FAIL bp_count got=%0d left=%0d required=10/0", n_pop, ed.size()); end
  endtask
  task automatic test_wrap;
    bit ok;
    clr;
    start_burst(16'hFFFE, 16'd4);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_done timeout got=0 required=1"); end
    repeat (2) tick;
    total++; if (n_iss != 4 || n_pop != 4 || ea.size() != 0) begin bad++; $display("FAIL wrap_counts iss=%0d pop=%0d required=4/4", n_iss, n_pop); end
  endtask
  task automatic test_zero_len;
    clr;
    start_burst(16'h0055, 16'd0);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_done got=%b busy=%b required=1/0", done, busy); end
    tick;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_pulse got=%b required=0", done); end
    repeat (4) tick;
    total++; if (n_iss != 0 || n_done != 1) begin bad++; $display("FAIL zero_counts iss=%0d done=%0d required=0/1", n_iss, n_done); end
  endtask
  task automatic test_busy_start;
    bit ok;
    clr;
    start_burst(16'h0100, 16'd3);
    tick;
    base = 16'h9000; len = 16'd5; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_done timeout got=0 required=1"); end
    repeat (6) tick;
    total++; if (n_iss != 3 || n_pop != 3 || n_done != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL busy_ignore iss=%0d pop=%0d done=%0d busy=%b required=3/3/1/0", n_iss, n_pop, n_done, busy);
    end
  endtask
  task automatic test_ready_pause;
    bit ok;
    int k;
    clr;
    start_burst(16'h0200, 16'd8);
    for (int i = 0; i < 50 && n_iss < 2; i++) tick;
    lramready = 1'b0;
    k = n_iss;
    repeat (5) tick;
    total++; if (n_iss != k || k != 2) begin bad++; $display("FAIL pause_issue got=%0d required=%0d", n_iss, 2); end
    lramready = 1'b1;
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL pause_done timeout got=0 required=1"); end
    repeat (2) tick;
    total++; if (n_iss != 8 || n_pop != 8 || ed.size() != 0) begin bad++; $display("FAIL pause_count iss=%0d pop=%0d required=8/8", n_iss, n_pop); end
  endtask
  task automatic test_reset_mid;
    bit ok;
    clr;
    start_burst(16'h2000, 16'd8);
    for (int i = 0; i < 50 && n_iss < 3; i++) tick;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rd_en, rd_addr, pix_valid, pix_data, busy, done, ovf} !== '0) begin
      bad++; $display("FAIL rstmid outputs got=%h required=0", {rd_en, rd_addr, pix_valid, pix_data, busy, done, ovf});
    end
    repeat (5) tick;
    rst_n = 1'b1;
    repeat (2) tick;
    total++; if (n_done != 0 || ovf !== 1'b0) begin bad++; $display("FAIL rstmid_abort done=%0d ovf=%b required=0/0", n_done, ovf); end
    clr;
    start_burst(16'h3000, 16'd2);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_new timeout got=0 required=1"); end
    repeat (2) tick;
    total++; if (n_pop != 2 || n_done != 1 || ovf !== 1'b0) begin bad++; $display("FAIL rstmid_new pop=%0d done=%0d ovf=%b required=2/1/0", n_pop, n_done, ovf); end
  endtask
  task automatic test_spurious;
    clr;
    spur = 1'b1;
    tick;
    spur = 1'b0;
    tick;
    total++; if (ovf !== 1'b1 || pix_valid !== 1'b0) begin bad++; $display("FAIL spur_set ovf=%b valid=%b required=1/0", ovf, pix_valid); end
    repeat (10) tick;
    total++; if (ovf !== 1'b1 || n_pop != 0) begin bad++; $display("FAIL spur_sticky ovf=%b pop=%0d required=1/0", ovf, n_pop); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL spur_clear got=%b required=0", ovf); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_zero_len;
    test_busy_start;
    test_ready_pause;
    test_reset_mid;
    test_spurious;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lram_fb_reader.md
LRAM_FB_READER -- requirements
Module: lram_fb_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 16: LRAM word-address width.
REQ-003 clk_i  in  1  single clock; all logic is rising-edge.
REQ-004 rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  one-cycle pulse that begins a burst read.
REQ-006 base_addr_i  in  ADDR_W  first word address, sampled on an accepted start_i.
REQ-007 length_i  in  16  number of words to read, sampled on an accepted start_i.
REQ-008 lramready_i  in  1  LRAM initialised and ready to accept reads.
REQ-009 rd_addr_o  out  ADDR_W  LRAM read address.
REQ-010 rd_clk_en_o  out  1  LRAM read clock enable; one cycle high issues one read.
REQ-011 rd_data_i  in  32  LRAM read data.
REQ-012 rd_datavalid_i  in  1  rd_data_i valid this cycle.
REQ-013 pix_data_o  out  32  output word (FIFO head).
REQ-014 pix_valid_o  out  1  pix_data_o is valid.
REQ-015 pix_ready_i  in  1  downstream accepts the word when both valid and ready are high.
REQ-016 busy_o  out  1  a burst is in progress.
REQ-017 done_o  out  1  one-cycle pulse after the last word of a burst is accepted downstream.
REQ-018 overflow_o  out  1  sticky: rd_datavalid_i was seen with no outstanding read.

Function
REQ-019 States: IDLE, WAIT_RDY, READ, DRAIN.
- IDLE -> WAIT_RDY on start_i with length_i != 0.
- WAIT_RDY -> READ when lramready_i is high.
- READ -> DRAIN after the last read is issued.
- DRAIN -> IDLE when the last word is accepted downstream, together with the done_o pulse.
REQ-020 When start_i arrives with length_i == 0, the block stays in IDLE and pulses done_o on the next cycle.
REQ-021 The block ignores start_i while busy_o is high.
REQ-022 busy_o is high in every state except IDLE.
REQ-023 In READ, the block issues one read per cycle (rd_clk_en_o=1) only when outstanding + fifo_count < FIFO_DEPTH and lramready_i is high. This credit rule guarantees the FIFO cannot overflow for any read latency.
REQ-024 rd_addr_o is base_addr_i + issue index, modulo 2^ADDR_W. It wraps from all-ones to 0 with no error.
REQ-025 When no read is issued, rd_addr_o holds its value and rd_clk_en_o is 0.
REQ-026 outstanding increments on each issued read and decrements on each rd_datavalid_i; both in the same cycle leave it unchanged.
REQ-027 On rd_datavalid_i with outstanding > 0, rd_data_i is written to the FIFO tail in that cycle.
REQ-028 On rd_datavalid_i with outstanding == 0, the data is dropped and overflow_o is set.
REQ-029 A FIFO write and a FIFO read (pix_valid_o & pix_ready_i) in the same cycle leave fifo_count unchanged. This holds when the FIFO is full.
REQ-030 pix_valid_o = (fifo_count != 0); pix_data_o comes straight from the FIFO head (first-word fall-through).
REQ-031 Read order equals issue order; the word count delivered downstream equals length_i exactly.
REQ-032 If lramready_i falls mid-burst, issue pauses and outstanding reads still complete. Issue resumes when lramready_i returns.
REQ-033 pix_data_o is stable while pix_valid_o=1 and pix_ready_i=0.

Reset
REQ-034 rst_n_i low asynchronously forces:
- state IDLE;
- rd_clk_en_o=0, rd_addr_o=0;
- pix_valid_o=0, pix_data_o=0;
- busy_o=0, done_o=0, overflow_o=0;
- FIFO pointers, fifo_count and outstanding = 0.
REQ-035 Reset mid-burst aborts the burst with no done_o. Any rd_datavalid_i after reset release with outstanding==0 sets overflow_o.
REQ-036 While rst_n_i is low, start_i is ignored.

Verification
REQ-037 Basic burst: base=0x4753, len=4, pix_ready_i=1, 2-cycle latency -> rd_addr_o 0x4753..0x4756 on consecutive cycles; pix_data_o in that order; one done_o; overflow_o=0.
REQ-038 Backpressure: len=10, pix_ready_i=0 for 20 cycles then 1 -> at most FIFO_DEPTH reads issued while stalled; all 10 words delivered in order with none lost or duplicated.
REQ-039 Wrap-around: base=0xFFFE, len=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-040 Boundaries: len=0 gives a done_o pulse with no rd_clk_en_o. start_i while busy gives no effect. lramready_i low 5 cycles mid-burst gives an issue pause with the correct final count.
REQ-041 Reset mid-burst: len=8, rst_n_i low after 3 issues -> all outputs at their reset values immediately; a new len=2 burst completes normally.
REQ-042 Spurious rd_datavalid_i in IDLE -> overflow_o=1 and stays 1 until reset; FIFO stays empty.
